// File: rtl/uart_rx_string.sv
// -----------------------------------------------------------------------------
// uart_rx_string
//   UART line receiver. It oversamples the serial line at 16x baud, deframes
//   8N1 bytes and collects them into a line buffer until the terminator arrives.
//   The completed line is presented right-aligned in a 256-bit word together
//   with its length. This is the same format the UART string sender consumes,
//   so a received command can drive other logic or be echoed back unchanged.
//
//   Optional feature (define UART_RX_STR_TIMEOUT_EN):
//     A partial line is flushed automatically once the line has been idle for
//     TIMEOUT_BITS bit-times. Without the define, a line is flushed only by
//     TERM_CHAR.
//
// Ports
//   clk          in   1    system clock
//   reset_n      in   1    asynchronous reset, active low
//   uart_rx_i    in   1    serial input, idle high
//   string_o     out  256  received chars, right-aligned; the first char is in
//                          byte string_len_o-1, unused high bytes are 0
//   string_len_o out  6    number of valid chars in string_o (0..MAX_LEN)
//   str_valid_o  out  1    1-clk pulse: string_o/string_len_o/str_ovf_o updated
//   str_ovf_o    out  1    chars were dropped from this string
//   frame_err_o  out  1    1-clk pulse: stop bit sampled low, byte discarded
//   busy_o       out  1    high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_string #(
  parameter int          SYS_FREQ     = 125,    // MHz
  parameter int          BAUD         = 9600,
  parameter int          MAX_LEN      = 32,     // 1..32 characters
  parameter logic [7:0]  TERM_CHAR    = 8'h0D,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         uart_rx_i,
  output logic [255:0] string_o,
  output logic [5:0]   string_len_o,
  output logic         str_valid_o,
  output logic         str_ovf_o,
  output logic         frame_err_o,
  output logic         busy_o
);

  // Rounded divider from the system clock down to the 16x oversampling tick.
  localparam int         DIV       = (SYS_FREQ * 1_000_000 + BAUD * 8) / (BAUD * 16);
  localparam int         DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [5:0] MAX_LEN_L = 6'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic               rx_meta_q, rx_q;
  logic [DIV_W-1:0]   div_q;
  logic               tick;
  logic [3:0]         cnt_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic               byte_done, stop_bad;
  logic [255:0]       line_q, line_d;
  logic [5:0]         len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               flush, timeout;

  // Two-flop synchroniser. It resets to the idle-high level so that releasing
  // reset cannot be mistaken for a start bit.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_q      <= rx_meta_q;
    end
  end

  // Free-running oversampling tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        div_q <= '0;
    else if (div_q == DIV_W'(DIV - 1))   div_q <= '0;
    else                                 div_q <= div_q + 1'b1;
  end
  assign tick = (div_q == DIV_W'(DIV - 1));

  // Frame FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Frame FSM: next-state logic.
  // NOTE: every combinational output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        S_IDLE:  if (!rx_q) state_d = S_START;
        // A start bit that is no longer low at mid-bit is treated as a glitch.
        S_START: if (cnt_q == 4'd7) state_d = rx_q ? S_IDLE : S_DATA;
        S_DATA:  if (cnt_q == 4'd15 && bit_q == 3'd7) state_d = S_STOP;
        S_STOP:  if (cnt_q == 4'd15) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Frame FSM: outputs.
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    byte_done = tick && (state_q == S_STOP) && (cnt_q == 4'd15) &&  rx_q;
    stop_bad  = tick && (state_q == S_STOP) && (cnt_q == 4'd15) && !rx_q;
  end

  // Tick counter, bit index and LSB-first shift register.
  // cnt restarts at the middle of the start bit, so each later cnt==15 lands
  // at the middle of a data or stop bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (tick) begin
      unique case (state_q)
        S_IDLE:  cnt_q <= '0;
        S_START: begin
          cnt_q <= (cnt_q == 4'd7) ? 4'd0 : cnt_q + 4'd1;
          bit_q <= '0;
        end
        S_DATA: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            shift_q <= {rx_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end
        end
        default: cnt_q <= cnt_q + 4'd1;
      endcase
    end
  end

`ifdef UART_RX_STR_TIMEOUT_EN
  // Counts idle bit-times while a partial line is pending. The count restarts
  // on every start bit, and after every flush.
  localparam int TMO_W = $clog2(TIMEOUT_BITS + 1);
  logic [3:0]       tmo_sub_q;
  logic [TMO_W-1:0] tmo_bits_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_sub_q  <= '0;
      tmo_bits_q <= '0;
    end else if (state_q != S_IDLE || len_q == 6'd0 || flush) begin
      tmo_sub_q  <= '0;
      tmo_bits_q <= '0;
    end else if (tick && !timeout) begin
      tmo_sub_q <= tmo_sub_q + 4'd1;
      if (tmo_sub_q == 4'd15) tmo_bits_q <= tmo_bits_q + 1'b1;
    end
  end
  assign timeout = (tmo_bits_q == TMO_W'(TIMEOUT_BITS));
`else
  assign timeout = 1'b0;
`endif

  // Line assembler. A received byte always takes priority over a timeout
  // flush in the same cycle.
  always_comb begin
    line_d = line_q;
    len_d  = len_q;
    ovf_d  = ovf_q;
    flush  = 1'b0;
    if (byte_done) begin
      if (shift_q == TERM_CHAR)       flush = (len_q != 6'd0);
      else if (len_q < MAX_LEN_L) begin
        line_d = {line_q[247:0], shift_q};
        len_d  = len_q + 6'd1;
      end else                        ovf_d = 1'b1;
    end else if (timeout) begin
      flush = (len_q != 6'd0);
    end
    if (flush) begin
      line_d = '0;
      len_d  = '0;
      ovf_d  = 1'b0;
    end
  end

  // The line buffer is reset so that a reset in the middle of a line discards it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      string_o     <= '0;
      string_len_o <= '0;
      str_ovf_o    <= 1'b0;
      str_valid_o  <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      line_q      <= line_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      str_valid_o <= flush;
      frame_err_o <= stop_bad;
      if (flush) begin
        string_o     <= line_q;
        string_len_o <= len_q;
        str_ovf_o    <= ovf_q;
      end
    end
  end

endmodule
